// File: rtl/pet_need_scheduler.sv
// ============================================================================
//  Module   : pet_need_scheduler
//  Purpose  : Owns the four pet need levels, decays them round-robin on time
//             ticks and raises them on arbitrated, debounced button actions.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pet_need_scheduler #(
    parameter int TICK_CYCLES = 12500000,
    parameter int TEST_DIV    = 10,
    parameter int DECAY_TICKS = 60,
    parameter int HOLD_CYCLES = 3125000
) (
    input  logic       clk,
    input  logic       reseteo,
    input  logic       btn_carino,
    input  logic       btn_comida,
    input  logic       btn_medicina,
    input  logic       btn_dormir,
    input  logic       modo_test,
    input  logic       test,
    output logic [1:0] nivel_animo,
    output logic [1:0] nivel_hambre,
    output logic [1:0] nivel_sueno,
    output logic [1:0] nivel_salud,
    output logic [1:0] slot,
    output logic       tick,
    output logic       led_animo,
    output logic       led_hambre,
    output logic       led_sueno,
    output logic       led_salud,
    output logic       alerta
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int SLOT_W = $clog2(DECAY_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST_NORM = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST_TEST = TICK_W'(TICK_CYCLES / TEST_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(DECAY_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST      = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FROZEN    = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_ANIMO  = 2'd0,
        S_HAMBRE = 2'd1,
        S_SUENO  = 2'd2,
        S_SALUD  = 2'd3
    } slot_t;

    slot_t             state;
    slot_t             state_next;
    logic [TICK_W-1:0] tick_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic              modo_q;
    logic              mode_chg;
    logic [TICK_W-1:0] tick_last;
    logic              decay;
    logic [3:0]        btns;
    logic [3:0]        hold_set;
    logic [3:0]        pend;
    logic [3:0]        grant;

    // ---------------- tick generator ----------------
    always_comb begin
        mode_chg  = modo_test ^ modo_q;
        tick_last = modo_test ? TICK_LAST_TEST : TICK_LAST_NORM;
        tick      = !mode_chg && (tick_cnt == tick_last);
    end

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo) begin
            tick_cnt <= '0;
            modo_q   <= 1'b0;
        end else begin
            modo_q <= modo_test;
            if (mode_chg || tick) tick_cnt <= '0;
            else                  tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // ---------------- slot scheduling ----------------
    assign decay = (tick && (slot_cnt == SLOT_LAST)) || (modo_test && test);

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo)   slot_cnt <= '0;
        else if (decay) slot_cnt <= '0;
        else if (tick)  slot_cnt <= slot_cnt + SLOT_W'(1);
    end

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo) state <= S_ANIMO;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (decay) begin
            unique case (state)
                S_ANIMO:  state_next = S_HAMBRE;
                S_HAMBRE: state_next = S_SUENO;
                S_SUENO:  state_next = S_SALUD;
                default:  state_next = S_ANIMO;
            endcase
        end
    end

    assign slot = state;

    // ---------------- button hold detection ----------------
    assign btns = {btn_dormir, btn_medicina, btn_comida, btn_carino};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hold
            logic [HOLD_W-1:0] cnt;
            // Parks at HOLD_FROZEN after firing so a held button yields one action.
            always_ff @(posedge clk or negedge reseteo) begin
                if (!reseteo)                cnt <= '0;
                else if (!btns[gi])          cnt <= '0;
                else if (cnt == HOLD_LAST)   cnt <= HOLD_FROZEN;
                else if (cnt != HOLD_FROZEN) cnt <= cnt + HOLD_W'(1);
            end
            assign hold_set[gi] = btns[gi] && (cnt == HOLD_LAST);
        end
    endgenerate

    // ---------------- recovery arbiter ----------------
    always_comb begin
        grant = 4'b0000;
        if      (pend[0]) grant = 4'b0001;
        else if (pend[1]) grant = 4'b0010;
        else if (pend[2]) grant = 4'b0100;
        else if (pend[3]) grant = 4'b1000;
    end

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo) pend <= 4'b0000;
        else          pend <= (pend & ~grant) | hold_set;
    end

    // ---------------- levels ----------------
    function automatic logic [1:0] upd(input logic [1:0] lvl, input logic dn, input logic up);
        logic [1:0] r;
        r = lvl;
        if (dn && !up && (lvl != 2'd0)) r = lvl - 2'd1;
        if (up && !dn && (lvl != 2'd3)) r = lvl + 2'd1;
        return r;
    endfunction

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo) begin
            nivel_animo  <= 2'd3;
            nivel_hambre <= 2'd3;
            nivel_sueno  <= 2'd3;
            nivel_salud  <= 2'd3;
        end else begin
            nivel_animo  <= upd(nivel_animo,  decay && (state == S_ANIMO),  grant[0]);
            nivel_hambre <= upd(nivel_hambre, decay && (state == S_HAMBRE), grant[1]);
            nivel_salud  <= upd(nivel_salud,  decay && (state == S_SALUD),  grant[2]);
            // Sleeping pet is exempt from the sleep decay.
            nivel_sueno  <= upd(nivel_sueno,  decay && (state == S_SUENO) && !btn_dormir, grant[3]);
        end
    end

    always_ff @(posedge clk or negedge reseteo) begin
        if (!reseteo) begin
            led_animo  <= 1'b1;
            led_hambre <= 1'b1;
            led_sueno  <= 1'b1;
            led_salud  <= 1'b1;
            alerta     <= 1'b0;
        end else begin
            led_animo  <= (nivel_animo  == 2'd3);
            led_hambre <= (nivel_hambre == 2'd3);
            led_sueno  <= (nivel_sueno  == 2'd3);
            led_salud  <= (nivel_salud  == 2'd3);
            alerta     <= (nivel_animo == 2'd0) || (nivel_hambre == 2'd0) ||
                          (nivel_sueno == 2'd0) || (nivel_salud  == 2'd0);
        end
    end

endmodule

`default_nettype wire
